cic_up_s3: RTL

CIC_UP_S3 -- requirements
Module: cic_up_s3

---
 rtl/cic_up_s3_if.sv | 36 +++
 rtl/cic_up_s3.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cic_up_s3_if.sv
// Stream bundle for the cic_up_s3 interpolator: global enable, low-rate
// input handshake, high-rate output and the underflow status flag.
interface cic_up_s3_if #(
    parameter int DATA_WIDTH = 12,
    parameter int OUT_WIDTH  = 16
);
    logic                         clk_enable;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_valid;
    logic                         uflow;

    // Driver side (sample source / sink and enable generator)
    modport master (
        output clk_enable,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  uflow
    );

    // Interpolator side
    modport slave (
        input  clk_enable,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        output uflow
    );
endinterface

// File: rtl/cic_up_s3.sv
// cic_up_s3: 3-stage CIC interpolator, differential delay 1, factor
// R = 2**RATE_LOG2, DC gain R^2. Combs run at the low rate (phase-0 slots),
// integrators run every enabled cycle on a zero-stuffed comb output.
// All arithmetic is modular two's complement at OUT_WIDTH; wrap inside the
// integrators is exact and cancels at the output.
//
// Optional feature: define CIC_UP_UFLOW_EN to enable sticky underflow
// detection (a phase-0 slot without in_valid after the first accepted
// sample). Without it uflow is tied low and the datapath is unchanged.
module cic_up_s3 #(
    parameter int DATA_WIDTH = 12,
    parameter int RATE_LOG2  = 2
) (
    input logic         clk,
    input logic         sys_rst_n,
    cic_up_s3_if.slave  bus
);
    localparam int OUT_WIDTH = DATA_WIDTH + 2 * RATE_LOG2;
    localparam int EXT_WIDTH = OUT_WIDTH - DATA_WIDTH;

    // Enabled edges from reset release until the first output is valid:
    // one for the comb register, three integrators, one output register.
    localparam logic [2:0] FILL_EDGES = 3'd5;

    typedef logic signed [OUT_WIDTH-1:0] acc_t;

    logic [RATE_LOG2-1:0] phase;
    logic                 slot;
    logic                 stuff;
    logic [2:0]           fill_cnt;

    acc_t x_ext;
    acc_t x_in;
    acc_t c1;
    acc_t c2;
    acc_t c3;
    acc_t d1;
    acc_t d2;
    acc_t d3;
    acc_t comb_q;
    acc_t int_in;
    acc_t int1;
    acc_t int2;
    acc_t int3;
    acc_t out_q;

    // Low-rate slot: the only cycle in which a sample can be taken
    assign slot         = bus.clk_enable & (phase == '0);
    assign bus.in_ready = slot;

    // Sign-extend, with zero insertion when the source has nothing ready
    assign x_ext = {{EXT_WIDTH{bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
    assign x_in  = bus.in_valid ? x_ext : '0;

    // Comb cascade evaluated combinationally, captured only at slots
    assign c1 = x_in - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    // comb_q carries a fresh value only in the cycle right after a slot;
    // every other high-rate cycle feeds zero into the integrators.
    assign stuff  = (phase == RATE_LOG2'(1));
    assign int_in = stuff ? comb_q : '0;

    // Phase counter: free-running modulo R while enabled
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase <= '0;
        end else if (bus.clk_enable) begin
            phase <= phase + RATE_LOG2'(1);
        end
    end

    // Comb delay line and comb output register, low-rate only
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d1     <= '0;
            d2     <= '0;
            d3     <= '0;
            comb_q <= '0;
        end else if (slot) begin
            d1     <= x_in;
            d2     <= c1;
            d3     <= c2;
            comb_q <= c3;
        end
    end

    // Integrator chain, each stage accumulating the previous stage's register
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            int1 <= '0;
            int2 <= '0;
            int3 <= '0;
        end else if (bus.clk_enable) begin
            int1 <= int1 + int_in;
            int2 <= int2 + int1;
            int3 <= int3 + int2;
        end
    end

    // Output register aligns the first term to four edges after acceptance
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_q <= '0;
        end else if (bus.clk_enable) begin
            out_q <= int3;
        end
    end

    // Pipeline fill timer: down-counts enabled edges, terminal count at zero
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fill_cnt <= FILL_EDGES;
        end else if (bus.clk_enable && (fill_cnt != 3'd0)) begin
            fill_cnt <= fill_cnt - 3'd1;
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = bus.clk_enable & (fill_cnt == 3'd0);

`ifdef CIC_UP_UFLOW_EN
    logic seen_sample;
    logic uflow_q;

    // Sticky underflow: a missed slot only counts once streaming has begun
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seen_sample <= 1'b0;
            uflow_q     <= 1'b0;
        end else if (slot) begin
            if (bus.in_valid) begin
                seen_sample <= 1'b1;
            end else if (seen_sample) begin
                uflow_q <= 1'b1;
            end
        end
    end

    assign bus.uflow = uflow_q;
`else
    assign bus.uflow = 1'b0;
`endif

endmodule
